// File: rtl/snake_body_if.sv
// Beam/control bundle between the direction decoder, game FSM and snake engine.
// Master drives the control/beam inputs; slave is the snake engine.
interface snake_body_if #(
  parameter int BIT = 10,
  parameter int LW  = 4
);
  logic           update;
  logic [BIT-1:0] x_pos;
  logic [BIT-1:0] y_pos;
  logic [2:0]     direction;
  logic           grow;
  logic [1:0]     game_state;
  logic           head_active;
  logic           body_active;
  logic           self_hit;
  logic [LW-1:0]  length;
  logic [2:0]     rgb;

  modport master (
    output update, x_pos, y_pos, direction, grow, game_state,
    input  head_active, body_active, self_hit, length, rgb
  );

  modport slave (
    input  update, x_pos, y_pos, direction, grow, game_state,
    output head_active, body_active, self_hit, length, rgb
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake head + trailing body on a SEG grid: move, wrap, grow, self-hit, draw.
// SNAKE_HEAD_COLOR_EN: head drawn yellow, otherwise whole snake is green.
module snake_body_engine #(
  parameter int BIT       = 10,
  parameter int SEG       = 16,
  parameter int MAX_LEN   = 8,
  parameter int START_LEN = 3,
  parameter int X_START   = 320,
  parameter int Y_START   = 240,
  parameter int H_FIELD   = 640,
  parameter int V_FIELD   = 480
) (
  input logic        clk,
  input logic        reset,
  snake_body_if.slave bus
);
  localparam int NS = MAX_LEN - 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    D_IDLE  = 3'd0,
    D_UP    = 3'd1,
    D_DOWN  = 3'd2,
    D_LEFT  = 3'd3,
    D_RIGHT = 3'd4
  } dir_e;

  logic [BIT-1:0] hx_q, hx_d, hy_q, hy_d;
  logic [BIT-1:0] sx_q [NS];
  logic [BIT-1:0] sx_d [NS];
  logic [BIT-1:0] sy_q [NS];
  logic [BIT-1:0] sy_d [NS];
  dir_e           dir_q, dir_d, din, eff;
  logic [LW-1:0]  len_q, len_d;
  logic           pend_q, pend_d, hit_q, hit_d;
  logic           play, over, dvalid, acc, step, hit_any;
  logic           head_on, body_on;

  function automatic dir_e rev_of(dir_e d);
    unique case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      D_RIGHT: return D_LEFT;
      default: return D_IDLE;
    endcase
  endfunction

  function automatic logic in_sq(logic [BIT-1:0] bx, logic [BIT-1:0] by,
                                 logic [BIT-1:0] px, logic [BIT-1:0] py);
    logic [BIT:0] ex, ey, x0, y0;
    ex = {1'b0, bx};
    ey = {1'b0, by};
    x0 = {1'b0, px};
    y0 = {1'b0, py};
    return (ex >= x0) && (ex < x0 + (BIT+1)'(SEG)) &&
           (ey >= y0) && (ey < y0 + (BIT+1)'(SEG));
  endfunction

  function automatic logic [BIT-1:0] seg_x0(int i);
    return BIT'(X_START - (i + 1) * SEG);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hx_q   <= BIT'(X_START);
      hy_q   <= BIT'(Y_START);
      dir_q  <= D_IDLE;
      len_q  <= LW'(START_LEN);
      pend_q <= 1'b0;
      hit_q  <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        sx_q[i] <= seg_x0(i);
        sy_q[i] <= BIT'(Y_START);
      end
    end else begin
      hx_q   <= hx_d;
      hy_q   <= hy_d;
      dir_q  <= dir_d;
      len_q  <= len_d;
      pend_q <= pend_d;
      hit_q  <= hit_d;
      for (int i = 0; i < NS; i++) begin
        sx_q[i] <= sx_d[i];
        sy_q[i] <= sy_d[i];
      end
    end
  end

  always_comb begin
    play   = (bus.game_state == 2'b01);
    over   = (bus.game_state == 2'b11);
    din    = dir_e'(bus.direction);
    dvalid = (bus.direction != 3'd0) && (bus.direction <= 3'd4);
    acc    = play && dvalid && (din != rev_of(dir_q));
    eff    = acc ? din : dir_q;
    step   = play && bus.update && (eff != D_IDLE);

    hit_any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if ((i < int'(len_q) - 1) && sx_q[i] == hx_q && sy_q[i] == hy_q)
        hit_any = 1'b1;
    end

    hx_d   = hx_q;
    hy_d   = hy_q;
    dir_d  = acc ? din : dir_q;
    len_d  = len_q;
    pend_d = pend_q | bus.grow;
    hit_d  = play && hit_any;
    for (int i = 0; i < NS; i++) begin
      sx_d[i] = sx_q[i];
      sy_d[i] = sy_q[i];
    end

    if (step) begin
      sx_d[0] = hx_q;
      sy_d[0] = hy_q;
      for (int i = 1; i < NS; i++) begin
        sx_d[i] = sx_q[i-1];
        sy_d[i] = sy_q[i-1];
      end
      // Compare against the edge first so subtraction never underflows
      unique case (eff)
        D_UP:    hy_d = (hy_q == '0) ? BIT'(V_FIELD - SEG) : hy_q - BIT'(SEG);
        D_DOWN:  hy_d = (hy_q == BIT'(V_FIELD - SEG)) ? '0 : hy_q + BIT'(SEG);
        D_LEFT:  hx_d = (hx_q == '0) ? BIT'(H_FIELD - SEG) : hx_q - BIT'(SEG);
        D_RIGHT: hx_d = (hx_q == BIT'(H_FIELD - SEG)) ? '0 : hx_q + BIT'(SEG);
        default: hx_d = hx_q;
      endcase
      if ((pend_q || bus.grow) && len_q < LW'(MAX_LEN))
        len_d = len_q + LW'(1);
      pend_d = 1'b0;
    end

    if (over) begin
      hx_d   = BIT'(X_START);
      hy_d   = BIT'(Y_START);
      dir_d  = D_IDLE;
      len_d  = LW'(START_LEN);
      pend_d = 1'b0;
      hit_d  = 1'b0;
      for (int i = 0; i < NS; i++) begin
        sx_d[i] = seg_x0(i);
        sy_d[i] = BIT'(Y_START);
      end
    end
  end

  always_comb begin
    head_on = in_sq(bus.x_pos, bus.y_pos, hx_q, hy_q);
    body_on = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if ((i < int'(len_q) - 1) && in_sq(bus.x_pos, bus.y_pos, sx_q[i], sy_q[i]))
        body_on = 1'b1;
    end
  end

  assign bus.head_active = head_on;
  assign bus.body_active = body_on;
  assign bus.self_hit    = hit_q;
  assign bus.length      = len_q;
`ifdef SNAKE_HEAD_COLOR_EN
  assign bus.rgb = head_on ? 3'b110 : 3'b010;
`else
  assign bus.rgb = 3'b010;
`endif
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed scoreboard bench for snake_body_engine (default parameters).
// Expected values are queued at stimulus time and popped at the sample point.
module tb_snake_body_engine;
  localparam logic [2:0] IDLE = 3'd0, UP = 3'd1, DOWN = 3'd2,
                         LEFT = 3'd3, RIGHT = 3'd4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  snake_body_if #(.BIT(10), .LW(4)) bus ();

  snake_body_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(string t, logic [31:0] e);
    exp_t x;
    x.tag = t;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mv(logic [2:0] d, logic g);
    bus.direction = d;
    bus.grow      = g;
    bus.update    = 1'b1;
    tick();
    bus.update    = 1'b0;
    bus.grow      = 1'b0;
    bus.direction = IDLE;
  endtask

  task automatic beam(int x, int y);
    bus.x_pos = 10'(x);
    bus.y_pos = 10'(y);
    #1;
  endtask

  task automatic head_at(string t, int x, int y);
    push({t, "_tl"}, 1);
    beam(x, y);
    pop_cmp(32'(bus.head_active));
    push({t, "_br"}, 1);
    beam(x + 15, y + 15);
    pop_cmp(32'(bus.head_active));
  endtask

  task automatic body_at(string t, int x, int y, logic e);
    push(t, 32'(e));
    beam(x, y);
    pop_cmp(32'(bus.body_active));
  endtask

  task automatic chk_len(string t, int e);
    push(t, 32'(e));
    pop_cmp(32'(bus.length));
  endtask

  task automatic chk_hit(string t, logic e);
    push(t, 32'(e));
    pop_cmp(32'(bus.self_hit));
  endtask

  task automatic game_over();
    bus.game_state = 2'b11;
    tick();
    bus.game_state = 2'b01;
  endtask

  initial begin
    reset          = 1'b1;
    bus.update     = 1'b0;
    bus.x_pos      = '0;
    bus.y_pos      = '0;
    bus.direction  = IDLE;
    bus.grow       = 1'b0;
    bus.game_state = 2'b01;
    tick();
    tick();
    reset = 1'b0;

    chk_len("rst_len", 3);
    chk_hit("rst_hit", 1'b0);
    head_at("rst_head", 320, 240);
    body_at("rst_seg0", 304, 240, 1'b1);
    body_at("rst_seg1", 288, 240, 1'b1);
    body_at("rst_seg2_hidden", 272, 240, 1'b0);

    // heading latched without update, then three steps
    bus.direction = RIGHT;
    tick();
    bus.direction = IDLE;
    head_at("no_step_head", 320, 240);
    for (int i = 0; i < 3; i++) mv(IDLE, 1'b0);
    head_at("t1_head", 368, 240);
    body_at("t1_seg0", 352, 240, 1'b1);
    body_at("t1_seg1", 336, 240, 1'b1);
    body_at("t1_old_hidden", 320, 240, 1'b0);
    chk_len("t1_len", 3);

    // reverse rejected, then turn up
    mv(LEFT, 1'b0);
    head_at("t2_rev", 384, 240);
    mv(UP, 1'b0);
    head_at("t2_up", 384, 224);

    // growth and saturation
    bus.grow = 1'b1;
    tick();
    bus.grow = 1'b0;
    chk_len("t3_pending_only", 3);
    mv(IDLE, 1'b0);
    chk_len("t3_grow1", 4);
    mv(IDLE, 1'b0);
    chk_len("t3_no_regrow", 4);
    for (int i = 0; i < 3; i++) begin
      bus.grow = 1'b1;
      tick();
    end
    bus.grow = 1'b0;
    mv(IDLE, 1'b0);
    chk_len("t3_multi_once", 5);
    mv(IDLE, 1'b1);
    mv(IDLE, 1'b1);
    mv(IDLE, 1'b1);
    chk_len("t3_max", 8);
    mv(IDLE, 1'b1);
    chk_len("t3_saturate", 8);
    head_at("t3_head", 384, 112);
    body_at("t3_seg6", 384, 224, 1'b1);

    // wrap around both edges
    game_over();
    head_at("t4_reset_head", 320, 240);
    for (int i = 0; i < 19; i++) mv(RIGHT, 1'b0);
    head_at("t4_edge_x", 624, 240);
    mv(IDLE, 1'b0);
    head_at("t4_wrap_x", 0, 240);
    for (int i = 0; i < 15; i++) mv(UP, 1'b0);
    head_at("t4_edge_y", 0, 0);
    mv(IDLE, 1'b0);
    head_at("t4_wrap_y", 0, 464);

    // hold freezes motion but latches grow
    bus.game_state = 2'b00;
    mv(DOWN, 1'b0);
    head_at("hold_head", 0, 464);
    bus.grow = 1'b1;
    tick();
    bus.grow = 1'b0;
    bus.game_state = 2'b01;
    chk_len("hold_len", 3);
    mv(IDLE, 1'b0);
    head_at("hold_resume", 0, 448);
    chk_len("hold_grow_used", 4);

    // self collision loop
    game_over();
    chk_len("t5_go_len", 3);
    mv(RIGHT, 1'b1);
    mv(RIGHT, 1'b1);
    chk_len("t5_len5", 5);
    mv(RIGHT, 1'b0);
    mv(DOWN, 1'b0);
    mv(LEFT, 1'b0);
    chk_hit("t5_before", 1'b0);
    mv(UP, 1'b0);
    head_at("t5_head", 352, 240);
    chk_hit("t5_same_cycle", 1'b0);
    tick();
    chk_hit("t5_hit", 1'b1);
    tick();
    chk_hit("t5_hold_hit", 1'b1);
    game_over();
    chk_hit("t5_go_hit", 1'b0);
    chk_len("t5_go_len2", 3);
    head_at("t5_go_head", 320, 240);

    // drawing boundaries and colour
    push("t6_head_in", 1);
    beam(320, 240);
    pop_cmp(32'(bus.head_active));
    push("t6_head_corner", 1);
    beam(335, 255);
    pop_cmp(32'(bus.head_active));
    push("t6_head_out", 0);
    beam(336, 240);
    pop_cmp(32'(bus.head_active));
    push("t6_head_out_y", 0);
    beam(320, 256);
    pop_cmp(32'(bus.head_active));
    push("t6_seg_head", 0);
    beam(304, 240);
    pop_cmp(32'(bus.head_active));
    body_at("t6_seg_body", 304, 240, 1'b1);
    body_at("t6_seg_edge", 319, 255, 1'b1);
`ifdef SNAKE_HEAD_COLOR_EN
    push("t6_rgb_head", 32'd6);
`else
    push("t6_rgb_head", 32'd2);
`endif
    beam(320, 240);
    pop_cmp(32'(bus.rgb));
    push("t6_rgb_body", 32'd2);
    beam(304, 240);
    pop_cmp(32'(bus.rgb));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Successor to the single-square snake head drawer: tracks a head plus up to MAX_LEN-1 trailing body segments on a SEG-pixel grid.
- Moves one grid step per `update` tick and keeps the current heading without new input.
- Grows on apple collection, wraps at the playfield edges and reports self-collision.
- Sits between the input/direction decoder and the VGA pixel mux; drives head/body pixel-active flags and colour for the current beam position.

Parameters:
BIT, 10, width of x/y coordinates
SEG, 16, segment size in pixels; also the step per move
MAX_LEN, 8, maximum segment count including head (>=2)
START_LEN, 3, length after reset/game over (1..MAX_LEN)
X_START, 320, head start x; must be >= (MAX_LEN-1)*SEG and a multiple of SEG
Y_START, 240, head start y; multiple of SEG
H_FIELD, 640, playfield width in pixels; multiple of SEG
V_FIELD, 480, playfield height in pixels; multiple of SEG

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
update  in  1  one-cycle move tick (once per frame or divided)
x_pos  in  BIT  current beam x
y_pos  in  BIT  current beam y
direction  in  3  0 IDLE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5-7 invalid
grow  in  1  one-cycle pulse: apple collected
game_state  in  2  01 PLAY, 11 GAME_OVER, other = hold
head_active  out  1  beam inside head square
body_active  out  1  beam inside any active body segment
self_hit  out  1  registered: head overlaps an active body segment
length  out  $clog2(MAX_LEN+1)  current segment count incl. head
rgb  out  3  pixel colour

Behaviour:
- Reset, and any cycle with game_state==GAME_OVER:
  - head=(X_START,Y_START); segment i (0..MAX_LEN-2) = (X_START-(i+1)*SEG, Y_START).
  - heading=IDLE, length=START_LEN, grow_pending=0, self_hit=0.
- Heading update every cycle in PLAY, when direction is 1-4 and is not the exact reverse of the current non-IDLE heading: heading <= direction. IDLE/invalid/reverse inputs are ignored; the last heading is kept.
- Step: occurs in a cycle with update=1 and game_state==PLAY.
  - Uses the effective direction = (accepted direction this cycle) else heading.
  - Effective IDLE: no step.
  - Otherwise: seg[0]<=head, seg[i]<=seg[i-1] (all MAX_LEN-1 slots shift), and head moves by SEG.
- Wrap-around:
  - LEFT at x==0 -> H_FIELD-SEG; RIGHT at x==H_FIELD-SEG -> 0.
  - UP at y==0 -> V_FIELD-SEG; DOWN at y==V_FIELD-SEG -> 0.
  - No BIT-width underflow is ever visible.
- Growth:
  - grow=1 sets grow_pending, or is consumed directly if a step happens the same cycle.
  - On a step with growth pending: length<=length+1, saturating at MAX_LEN; pending is cleared even when saturated.
  - Multiple grow pulses before one step count once.
- Active body segments are seg[0..length-2]. Slots beyond that still shift but are never drawn or compared.
- self_hit:
  - Registered each cycle as: PLAY and any active seg == head.
  - Valid 1 cycle after the step that caused the overlap.
  - Stays high while the overlap persists; the game FSM converts it to GAME_OVER.
- Drawing (combinational on x_pos/y_pos and registered positions):
  - head_active = x in [hx, hx+SEG) and y in [hy, hy+SEG).
  - body_active = OR over active segs of the same test.
  - Compares use BIT+1 bits so hx+SEG cannot overflow.
- game_state 00/10: positions, heading, length frozen; grow pulses still latch.

Optional Feature:
- Macro: SNAKE_HEAD_COLOR_EN.
- Defined: rgb=3'b110 (yellow) when head_active, else 3'b010 (green).
- Undefined: rgb constant 3'b010.

Test Plan:
1. Reset, PLAY, direction=RIGHT one cycle, 3 updates -> head x 320->336->352->368, y=240; length=3; seg[0]=(352,240), seg[1]=(336,240).
2. Heading RIGHT, apply direction=LEFT, then update -> reverse rejected, head x+=16; then UP+update -> head y=224.
3. grow pulse, then 2 updates -> length 3->4 after first step only; with MAX_LEN=4, another grow+update -> stays 4.
4. Head at x=624 moving RIGHT, update -> head x=0; head at y=0 moving UP -> y=464.
5. Length 5, steps RIGHT, DOWN, LEFT, UP -> self_hit=1 exactly 1 cycle after the 4th step; then GAME_OVER for 1 cycle -> head (320,240), length 3, self_hit 0.
6. Head at (320,240): beam (320,240) -> head_active=1; (335,255) -> 1; (336,240) -> 0; beam on seg[0] (304,240) -> body_active=1, head_active=0; with macro, rgb=110 at head.
